// File: rtl/free_list_if.sv
// Bundle of the rename-side signals of the physical-register free list.
// The free list is the slave; rename/ROB logic (or a bench) is the master.
interface free_list_if #(
    parameter int PHYS_W = 6,
    parameter int CNT_W  = 6
);
    logic              flush_valid;
    logic              alloc_valid;
    logic [PHYS_W-1:0] alloc_pd;
    logic              alloc_en;
    logic              commit_free_valid;
    logic [PHYS_W-1:0] commit_free_pd;
    logic              recover_free_valid;
    logic [PHYS_W-1:0] recover_free_pd;
    logic [CNT_W-1:0]  free_count;
    logic              underflow_err;
    logic              overflow_err;

    modport master (
        output flush_valid, alloc_en,
        output commit_free_valid, commit_free_pd,
        output recover_free_valid, recover_free_pd,
        input  alloc_valid, alloc_pd, free_count,
        input  underflow_err, overflow_err
    );

    modport slave (
        input  flush_valid, alloc_en,
        input  commit_free_valid, commit_free_pd,
        input  recover_free_valid, recover_free_pd,
        output alloc_valid, alloc_pd, free_count,
        output underflow_err, overflow_err
    );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags feeding the rename stage.
// One pop per renamed rd-writing instruction; up to two returns per cycle
// (ROB commit first, then ROB recovery walk). Flush restores the reset
// contents so the list matches an identity-mapped rename table.
module free_list #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int PHYS_W    = $clog2(PHYS_REGS),
    parameter int DEPTH     = PHYS_REGS - ARCH_REGS,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input logic        clk,
    input logic        rst,
    free_list_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CX_W  = CNT_W + 1;  // one spare bit so intermediate sums never wrap

    logic [PHYS_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_underflow;
    logic              r_overflow;

    logic              w_pop;
    logic              w_underflow;
    logic              w_commit_req;
    logic              w_commit_acc;
    logic              w_recover_req;
    logic              w_recover_acc;
    logic              w_overflow;
    logic [CX_W-1:0]   w_cnt_base;
    logic [CX_W-1:0]   w_cnt_mid;
    logic [CX_W-1:0]   w_cnt_final;
    logic [PTR_W-1:0]  w_recover_slot;
    logic [PTR_W-1:0]  w_tail_next;
    logic [PTR_W-1:0]  w_head_next;

    // Pointer increment with explicit wrap so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Accept/reject decisions: pop first, then commit push, then recover push.
    // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
    always_comb begin
        w_pop          = bus.alloc_en && (r_count != '0);
        w_underflow    = bus.alloc_en && (r_count == '0);
        w_commit_req   = bus.commit_free_valid && (bus.commit_free_pd != '0);
        w_recover_req  = bus.recover_free_valid && (bus.recover_free_pd != '0);
        w_cnt_base     = {1'b0, r_count} - {{CNT_W{1'b0}}, w_pop};
        w_commit_acc   = w_commit_req && (w_cnt_base < CX_W'(DEPTH));
        w_cnt_mid      = w_cnt_base + {{CNT_W{1'b0}}, w_commit_acc};
        w_recover_acc  = w_recover_req && (w_cnt_mid < CX_W'(DEPTH));
        w_cnt_final    = w_cnt_mid + {{CNT_W{1'b0}}, w_recover_acc};
        w_overflow     = (w_commit_req && !w_commit_acc) || (w_recover_req && !w_recover_acc);
        w_recover_slot = w_commit_acc ? ptr_inc(r_tail) : r_tail;
        w_tail_next    = w_recover_acc ? ptr_inc(w_recover_slot) : w_recover_slot;
        w_head_next    = w_pop ? ptr_inc(r_head) : r_head;
    end

    // State update: reset and flush reload the free tags; otherwise pop/push.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is reset on purpose -- its contents are the architectural free tags, not don't-care data.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= PHYS_W'(ARCH_REGS + i);
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= CNT_W'(DEPTH);
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (bus.flush_valid) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= PHYS_W'(ARCH_REGS + i);
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= CNT_W'(DEPTH);
        end else begin
            if (w_commit_acc)  r_mem[r_tail]         <= bus.commit_free_pd;
            if (w_recover_acc) r_mem[w_recover_slot] <= bus.recover_free_pd;
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_cnt_final[CNT_W-1:0];
            if (w_underflow) r_underflow <= 1'b1;
            if (w_overflow)  r_overflow  <= 1'b1;
        end
    end

    assign bus.alloc_valid   = (r_count != '0);
    assign bus.alloc_pd      = r_mem[r_head];
    assign bus.free_count    = r_count;
    assign bus.underflow_err = r_underflow;
    assign bus.overflow_err  = r_overflow;
endmodule
